// File: rtl/mont_mul_pkg.sv
// Shared FSM state constants and default width for the Montgomery conversion and multiply stages.
// Both stages use these state constants so that their start/end handshakes chain directly.
package mont_mul_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } mm_state_t;

    // An R exponent wider than the datapath behaves as the full datapath width.
    function automatic logic [7:0] clamp_len(input logic [7:0] raw_len, input logic [7:0] max_len);
        return (raw_len > max_len) ? max_len : raw_len;
    endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration, purely combinational: t_next = (t + a_bit*b + q*n) / 2.
// Two guard bits keep the sum below 4N without overflow, given that t < 2N on entry.
module mont_step
    import mont_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH+1:0] t,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH+1:0] t_next
);

    logic [WIDTH+1:0] t1;
    logic [WIDTH+1:0] t2;

    always_comb begin
        t1     = t + (a_bit ? {2'b00, b} : '0);
        // Adding the odd modulus makes the sum even, so the shift below divides exactly.
        t2     = t1 + (t1[0] ? {2'b00, n} : '0);
        t_next = t2 >> 1;
    end

endmodule

// File: rtl/mont_mul.sv
// Bit-serial Montgomery multiplier: mm_out = a*b*2^-len mod N. The result appears len+2 cycles after the start edge.
// There is no backpressure: mm_start is honoured only in IDLE, and the result is valid only during the single mm_end cycle.
module mont_mul
    import mont_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mm_start,
    input  logic [7:0]       len,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] modulus,
    output logic             mm_end,
    output logic [WIDTH-1:0] mm_out
);

    localparam logic [7:0] MAX_LEN = 8'(WIDTH);

    mm_state_t        state;
    mm_state_t        state_nxt;
    logic [WIDTH+1:0] t_reg;
    logic [WIDTH+1:0] t_step;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] n_reg;
    logic [7:0]       iter;
    logic [7:0]       len_eff;

    assign len_eff = clamp_len(len, MAX_LEN);

    mont_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .t      (t_reg),
        .a_bit  (a_reg[0]),
        .b      (b_reg),
        .n      (n_reg),
        .t_next (t_step)
    );

    always_comb begin
        state_nxt = state;
        mm_end    = 1'b0;
        mm_out    = '0;
        case (state)
            IDLE: begin
                if (mm_start) begin
                    state_nxt = (len_eff == 8'd0) ? SUB : CALC;
                end
            end
            CALC: begin
                if (iter == 8'd1) begin
                    state_nxt = SUB;
                end
            end
            SUB: begin
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                mm_end    = 1'b1;
                mm_out    = t_reg[WIDTH-1:0];
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            t_reg <= '0;
            a_reg <= '0;
            b_reg <= '0;
            n_reg <= '0;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (mm_start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        n_reg <= modulus;
                        t_reg <= '0;
                        iter  <= len_eff;
                    end
                end
                CALC: begin
                    t_reg <= t_step;
                    a_reg <= a_reg >> 1;
                    iter  <= iter - 8'd1;
                end
                SUB: begin
                    // t < 2N here, so a single conditional subtract fully reduces it.
                    if (t_reg >= {2'b00, n_reg}) begin
                        t_reg <= t_reg - {2'b00, n_reg};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul.sv
// Randomized and directed scoreboard bench for mont_mul, checked against a modular-arithmetic reference model.
module tb_mont_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        mm_start;
    logic [7:0]  len;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] modulus;
    logic        mm_end;
    logic [31:0] mm_out;

    always #5 clk = ~clk;

    mont_mul #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .mm_start (mm_start),
        .len      (len),
        .a_in     (a_in),
        .b_in     (b_in),
        .modulus  (modulus),
        .mm_end   (mm_end),
        .mm_out   (mm_out)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Compute a*b mod N, then multiply by 2^-1 mod N once per bit of R.
    function automatic logic [31:0] ref_mm(input longint unsigned a, input longint unsigned b,
                                           input longint unsigned n, input int l);
        longint unsigned x;
        if (l == 0) return 32'd0;
        x = (a * b) % n;
        for (int i = 0; i < l; i++) begin
            x = x[0] ? ((x + n) >> 1) : (x >> 1);
        end
        return x[31:0];
    endfunction

    function automatic int eff_len(input logic [7:0] l);
        return (l > 8'd32) ? 32 : int'(l);
    endfunction

    // Monitor: pops the scoreboard on every mm_end and requires zero outputs otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (mm_end === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_end: mm_end high at cycle %0d with mm_out=%h, no run expected", cyc, mm_out);
                end else begin
                    e = sb.pop_front();
                    n_vec++;
                    if (mm_out !== e.res) begin
                        n_err++;
                        $display("FAIL result: got %h want %h", mm_out, e.res);
                    end
                    n_vec++;
                    if (cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL latency: mm_end at cycle %0d want %0d", cyc, e.cyc);
                    end
                end
            end else begin
                n_vec++;
                if (mm_end !== 1'b0 || mm_out !== 32'd0) begin
                    n_err++;
                    $display("FAIL idle_out: mm_end=%b mm_out=%h want 0/0 at cycle %0d", mm_end, mm_out, cyc);
                end
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at the negedge after the sampling edge.
    task automatic issue(input logic [7:0] l, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] n, input logic [31:0] exp_res, input bit expect_end);
        exp_t e;
        len = l; a_in = a; b_in = b; modulus = n; mm_start = 1'b1;
        if (expect_end) begin
            e.res = exp_res;
            e.cyc = cyc + 2 + eff_len(l);
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        mm_start = 1'b0;
        len = 8'($urandom); a_in = $urandom; b_in = $urandom; modulus = $urandom;
    endtask

    task automatic run(input logic [7:0] l, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] n, input logic [31:0] exp_res);
        issue(l, a, b, n, exp_res, 1'b1);
        repeat (eff_len(l) + 2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          w;
        int          leff;
        logic [7:0]  l;
        logic [31:0] mask, n, a, b;
        exp_t        e;

        rst = 1'b1; mm_start = 1'b0; len = 8'd0; a_in = '0; b_in = '0; modulus = '0;
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(8'd4, 32'd5, 32'd7, 32'd13, 32'd3);
        run(8'd4, 32'd1, 32'd5, 32'd13, 32'd6);
        run(8'd32, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'd5);
        run(8'd2, 32'd2, 32'd2, 32'd3, 32'd1);
        run(8'd0, 32'd5, 32'd7, 32'd13, 32'd0);
        run(8'd40, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'd5);

        // A start pulse during CALC must be dropped, not queued.
        issue(8'd4, 32'd5, 32'd7, 32'd13, 32'd3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        len = 8'd4; a_in = 32'd1; b_in = 32'd5; modulus = 32'd13; mm_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mm_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        repeat (10) @(negedge clk);

        // A start pulse during DONE must also be ignored.
        issue(8'd4, 32'd5, 32'd7, 32'd13, 32'd3, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        len = 8'd4; a_in = 32'd1; b_in = 32'd5; modulus = 32'd13; mm_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mm_start = 1'b0;
        repeat (10) @(negedge clk);

        // Reset at CALC edge 2 aborts the run without producing mm_end.
        issue(8'd4, 32'd5, 32'd7, 32'd13, 32'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run(8'd4, 32'd5, 32'd7, 32'd13, 32'd3);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       l = 8'd0;
                1:       l = 8'($urandom_range(33, 255));
                default: l = 8'($urandom_range(1, 32));
            endcase
            leff = eff_len(l);
            mask = (leff == 32) ? 32'hFFFF_FFFF : ((32'd1 << leff) - 32'd1);
            n = ($urandom & mask) | 32'd1;
            a = $urandom % n;
            b = $urandom % n;
            run(l, a, b, n, ref_mm(64'(a), 64'(b), 64'(n), leff));
        end

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++; n_err++;
            $display("FAIL missing_end: no mm_end by cycle %0d, want result %h at cycle %0d", cyc, e.res, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
